// File: rtl/mult_arbiter_pkg.sv
// Shared types and widths for the mult11x11 sharing arbiter.
package mult_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        START,
        BUSY,
        RESP
    } arb_state_t;

    localparam int unsigned MULT_LAT = 30;
    localparam int unsigned FRAC_W   = 10;
    localparam int unsigned PROD_W   = 22;

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side and multiplier-side signals of mult_arbiter.
interface mult_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) ();

    logic [NREQ-1:0]              req;
    logic [NREQ-1:0][FRAC_W-1:0]  op_a;
    logic [NREQ-1:0][FRAC_W-1:0]  op_b;
    logic [NREQ-1:0]              rsp_valid;
    logic [PROD_W-1:0]            rsp_result;
    logic                         rsp_err;
    logic                         busy;
    logic                         mult_reset;
    logic                         mult_st;
    logic [FRAC_W-1:0]            mult_f1;
    logic [FRAC_W-1:0]            mult_f2;
    logic                         mult_done;
    logic [PROD_W-1:0]            mult_result;

    modport slave (
        input  req, op_a, op_b, mult_done, mult_result,
        output rsp_valid, rsp_result, rsp_err, busy,
               mult_reset, mult_st, mult_f1, mult_f2
    );

    modport master (
        output req, op_a, op_b, mult_done, mult_result,
        input  rsp_valid, rsp_result, rsp_err, busy,
               mult_reset, mult_st, mult_f1, mult_f2
    );

endinterface

// File: rtl/mult_arbiter_rr.sv
// Combinational round-robin pick: lowest index at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  gnt_oh,
    output logic [IDX_W-1:0] gnt_idx
);

    int unsigned      j;
    logic [IDX_W-1:0] jj;
    logic             found;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = IDX_W'(j);
            if (!found && req[jj]) begin
                found       = 1'b1;
                gnt_oh[jj]  = 1'b1;
                gnt_idx     = jj;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one mult11x11 between NREQ requesters; owns the multiplier reset so
// its sticky done and loop counter are cleared before every operation.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic          clk,
    input  logic          reset,
    mult_arbiter_if.slave bus
);

    localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT);

    arb_state_t        state_q, state_d;
    logic [FRAC_W-1:0] a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0]  id_q, id_d, rr_ptr_q, rr_ptr_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              clr_q, clr_d, err_q, err_d;
    logic [PROD_W-1:0] res_q, res_d;

    logic [NREQ-1:0]   gnt_oh;
    logic [IDX_W-1:0]  gnt_idx;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req     (bus.req),
        .rr_ptr  (rr_ptr_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        tcnt_d   = tcnt_q;
        clr_d    = 1'b0;
        err_d    = err_q;
        res_d    = res_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    a_d = '0;
                    b_d = '0;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        a_d = a_d | ({FRAC_W{gnt_oh[IDX_W'(i)]}} & bus.op_a[IDX_W'(i)]);
                        b_d = b_d | ({FRAC_W{gnt_oh[IDX_W'(i)]}} & bus.op_b[IDX_W'(i)]);
                    end
                    id_d    = gnt_idx;
                    clr_d   = 1'b1;
                    state_d = CLR;
                end
            end
            CLR:   state_d = START;
            START: begin
                tcnt_d  = '0;
                state_d = BUSY;
            end
            BUSY: begin
                tcnt_d = tcnt_q + 1'b1;
                // done outranks the timeout on the same cycle
                if (bus.mult_done) begin
                    res_d   = bus.mult_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rr_ptr_d = (id_q == IDX_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
            tcnt_q   <= '0;
            clr_q    <= 1'b0;
            err_q    <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            tcnt_q   <= tcnt_d;
            clr_q    <= clr_d;
            err_q    <= err_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (state_q == RESP) bus.rsp_valid[id_q] = 1'b1;
    end

    assign bus.rsp_result = res_q;
    assign bus.rsp_err    = (state_q == RESP) && err_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.mult_reset = reset | clr_q;
    assign bus.mult_st    = (state_q == START);
    assign bus.mult_f1    = a_q;
    assign bus.mult_f2    = b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter with a behavioural mult11x11 beside it.
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 40;
    localparam int unsigned IDX_W   = $clog2(NREQ);
    localparam int unsigned LAT_OK  = MULT_LAT + 4;   // negedges from drive to rsp_valid
    localparam int unsigned PERIOD  = MULT_LAT + 5;
    localparam int unsigned LAT_TO  = TIMEOUT + 3;
    localparam int unsigned WAITMAX = LAT_TO + 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mult_arbiter_if #(.NREQ(NREQ)) bus ();

    mult_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned m_ptr    = 0;
    bit          mult_stuck = 1'b0;
    int unsigned m_cnt;
    bit          m_run;

    function automatic logic [PROD_W-1:0] prod(input int unsigned a, input int unsigned b);
        return PROD_W'((1024 + a) * (1024 + b));
    endfunction

    function automatic int unsigned pick(input logic [NREQ-1:0] m, input int unsigned p);
        int unsigned idx;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (p + k) % NREQ;
            if (m[IDX_W'(idx)]) return idx;
        end
        return 0;
    endfunction

    // mult11x11: sticky done 30 cycles after the edge that samples start
    always @(posedge clk) begin
        if (bus.mult_reset) begin
            m_run           <= 1'b0;
            m_cnt           <= 0;
            bus.mult_done   <= 1'b0;
            bus.mult_result <= '0;
        end else if (bus.mult_st) begin
            m_run <= 1'b1;
            m_cnt <= 0;
        end else if (m_run) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == MULT_LAT) begin
                m_run <= 1'b0;
                if (!mult_stuck) begin
                    bus.mult_done   <= 1'b1;
                    bus.mult_result <= prod(32'(bus.mult_f1), 32'(bus.mult_f2));
                end
            end
        end
    end

    task automatic wait_rsp(input int unsigned max, output bit got, output int unsigned n);
        got = 1'b0;
        n   = 0;
        while (!got && n < max) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid != '0) got = 1'b1;
        end
    endtask

    // Drive mask from an idle negedge, capture the response, return to idle.
    task automatic issue(input logic [NREQ-1:0] mask, output bit got, output int unsigned n,
                         output logic [NREQ-1:0] v, output logic [PROD_W-1:0] r, output logic e);
        bus.req = mask;
        wait_rsp(WAITMAX, got, n);
        v = bus.rsp_valid;
        r = bus.rsp_result;
        e = bus.rsp_err;
        bus.req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_result !== '0) begin n_fail++; $display("FAIL reset_rsp_result: got %h expected 0", bus.rsp_result); end
        n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.mult_st !== 1'b0) begin n_fail++; $display("FAIL reset_mult_st: got %b expected 0", bus.mult_st); end
        n_checks++; if (bus.mult_f1 !== '0 || bus.mult_f2 !== '0) begin n_fail++; $display("FAIL reset_operands: got %h/%h expected 0/0", bus.mult_f1, bus.mult_f2); end
        n_checks++; if (bus.mult_reset !== 1'b1) begin n_fail++; $display("FAIL reset_mult_reset: got %b expected 1", bus.mult_reset); end
        reset = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        n_checks++; if (bus.mult_reset !== 1'b0) begin n_fail++; $display("FAIL idle_mult_reset: got %b expected 0", bus.mult_reset); end
    endtask

    task automatic test_single();
        bit got; int unsigned n, w;
        bus.op_a[0] = '0;
        bus.op_b[0] = '0;
        bus.req = NREQ'(1);
        w = pick(bus.req, m_ptr);
        @(negedge clk);
        n_checks++; if (bus.mult_reset !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_clr: got mult_reset=%b busy=%b expected 1/1", bus.mult_reset, bus.busy); end
        bus.req = '0;
        @(negedge clk);
        n_checks++; if (bus.mult_st !== 1'b1 || bus.mult_reset !== 1'b0) begin n_fail++; $display("FAIL single_start: got mult_st=%b mult_reset=%b expected 1/0", bus.mult_st, bus.mult_reset); end
        @(negedge clk);
        n_checks++; if (bus.mult_st !== 1'b0) begin n_fail++; $display("FAIL single_st_pulse: got %b expected 0", bus.mult_st); end
        wait_rsp(WAITMAX, got, n);
        n = n + 3;
        n_checks++; if (!got) begin n_fail++; $display("FAIL single_got: got no rsp_valid expected one"); end
        n_checks++; if (n !== LAT_OK) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", n, LAT_OK); end
        n_checks++; if (bus.rsp_valid !== (NREQ'(1) << w)) begin n_fail++; $display("FAIL single_valid: got %b expected %b", bus.rsp_valid, NREQ'(1) << w); end
        n_checks++; if (bus.rsp_result !== 22'h100000) begin n_fail++; $display("FAIL single_result: got %h expected 100000", bus.rsp_result); end
        n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", bus.rsp_err); end
        m_ptr = (w + 1) % NREQ;
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== '0) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 0", bus.rsp_valid); end
    endtask

    task automatic test_back_to_back();
        bit got; int unsigned n, w; logic [NREQ-1:0] v; logic [PROD_W-1:0] r; logic e;
        bus.op_a[2] = 10'h200;
        bus.op_b[2] = 10'h200;
        w = pick(NREQ'(4), m_ptr);
        issue(NREQ'(4), got, n, v, r, e);
        n_checks++; if (!got || n !== LAT_OK) begin n_fail++; $display("FAIL b2b1_latency: got %0d (seen=%b) expected %0d", n, got, LAT_OK); end
        n_checks++; if (v !== (NREQ'(1) << w)) begin n_fail++; $display("FAIL b2b1_valid: got %b expected %b", v, NREQ'(1) << w); end
        n_checks++; if (r !== 22'h240000 || e !== 1'b0) begin n_fail++; $display("FAIL b2b1_result: got %h err=%b expected 240000 err=0", r, e); end
        m_ptr = (w + 1) % NREQ;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.rsp_result !== 22'h240000) begin n_fail++; $display("FAIL result_hold: got %h expected 240000", bus.rsp_result); end
        bus.op_a[2] = 10'h3FF;
        bus.op_b[2] = 10'h001;
        w = pick(NREQ'(4), m_ptr);
        issue(NREQ'(4), got, n, v, r, e);
        n_checks++; if (!got || n !== LAT_OK) begin n_fail++; $display("FAIL b2b2_latency: got %0d (seen=%b) expected %0d", n, got, LAT_OK); end
        n_checks++; if (r !== prod(32'h3FF, 32'h001) || e !== 1'b0) begin n_fail++; $display("FAIL b2b2_result: got %h err=%b expected %h err=0", r, e, prod(32'h3FF, 32'h001)); end
        m_ptr = (w + 1) % NREQ;
    endtask

    task automatic test_all_four();
        bit got; int unsigned n, w;
        int unsigned ra[NREQ], rb[NREQ];
        reset = 1'b1;
        for (int unsigned i = 0; i < NREQ; i++) begin
            ra[i] = $urandom_range(0, 1023);
            rb[i] = $urandom_range(0, 1023);
            bus.op_a[IDX_W'(i)] = FRAC_W'(ra[i]);
            bus.op_b[IDX_W'(i)] = FRAC_W'(rb[i]);
        end
        bus.req = '1;
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w = pick(bus.req, m_ptr);
            wait_rsp(WAITMAX, got, n);
            n_checks++; if (!got || n !== ((k == 0) ? LAT_OK : PERIOD)) begin n_fail++; $display("FAIL all4_spacing[%0d]: got %0d (seen=%b) expected %0d", k, n, got, (k == 0) ? LAT_OK : PERIOD); end
            n_checks++; if (bus.rsp_valid !== (NREQ'(1) << w)) begin n_fail++; $display("FAIL all4_order[%0d]: got %b expected %b", k, bus.rsp_valid, NREQ'(1) << w); end
            n_checks++; if (bus.rsp_result !== prod(ra[w], rb[w])) begin n_fail++; $display("FAIL all4_result[%0d]: got %h expected %h", k, bus.rsp_result, prod(ra[w], rb[w])); end
            bus.req = bus.req & ~(NREQ'(1) << w);
            m_ptr = (w + 1) % NREQ;
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit got; int unsigned n, w; logic [NREQ-1:0] v; logic [PROD_W-1:0] r; logic e;
        mult_stuck = 1'b1;
        bus.op_a[3] = 10'h155;
        bus.op_b[3] = 10'h2AA;
        w = pick(NREQ'(8), m_ptr);
        issue(NREQ'(8), got, n, v, r, e);
        n_checks++; if (!got || n !== LAT_TO) begin n_fail++; $display("FAIL timeout_latency: got %0d (seen=%b) expected %0d", n, got, LAT_TO); end
        n_checks++; if (v !== (NREQ'(1) << w)) begin n_fail++; $display("FAIL timeout_valid: got %b expected %b", v, NREQ'(1) << w); end
        n_checks++; if (e !== 1'b1 || r !== '0) begin n_fail++; $display("FAIL timeout_err: got err=%b result=%h expected err=1 result=0", e, r); end
        m_ptr = (w + 1) % NREQ;
        mult_stuck = 1'b0;
    endtask

    task automatic test_reset_in_busy();
        bit got; int unsigned n, w, pulses; logic [NREQ-1:0] v; logic [PROD_W-1:0] r; logic e;
        bus.op_a[0] = 10'h0F0;
        bus.op_b[0] = 10'h00F;
        bus.req = NREQ'(1);
        repeat (10) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre: got %b expected 1", bus.busy); end
        bus.req = '0;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.mult_reset !== 1'b1) begin n_fail++; $display("FAIL rst_mult_reset: got %b expected 1", bus.mult_reset); end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin n_fail++; $display("FAIL rst_idle: got busy=%b valid=%b expected 0/0", bus.busy, bus.rsp_valid); end
        reset = 1'b0;
        m_ptr = 0;
        pulses = 0;
        repeat (LAT_TO) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_dropped: got %0d pulses expected 0", pulses); end
        bus.op_a[1] = FRAC_W'($urandom_range(0, 1023));
        bus.op_b[1] = FRAC_W'($urandom_range(0, 1023));
        w = pick(NREQ'(2), m_ptr);
        issue(NREQ'(2), got, n, v, r, e);
        n_checks++; if (!got || n !== LAT_OK || v !== (NREQ'(1) << w)) begin n_fail++; $display("FAIL rst_after_req: got n=%0d valid=%b expected n=%0d valid=%b", n, v, LAT_OK, NREQ'(1) << w); end
        n_checks++; if (r !== prod(32'(bus.op_a[1]), 32'(bus.op_b[1]))) begin n_fail++; $display("FAIL rst_after_result: got %h expected %h", r, prod(32'(bus.op_a[1]), 32'(bus.op_b[1]))); end
        m_ptr = (w + 1) % NREQ;
    endtask

    task automatic test_operand_change();
        bit got; int unsigned n, w, idx, a0, b0;
        idx = $urandom_range(0, NREQ - 1);
        a0  = $urandom_range(0, 1023);
        b0  = $urandom_range(0, 1023);
        bus.op_a[IDX_W'(idx)] = FRAC_W'(a0);
        bus.op_b[IDX_W'(idx)] = FRAC_W'(b0);
        bus.req = NREQ'(1) << idx;
        w = pick(bus.req, m_ptr);
        @(negedge clk);
        bus.op_a[IDX_W'(idx)] = FRAC_W'(a0 ^ $urandom_range(1, 1023));
        bus.op_b[IDX_W'(idx)] = FRAC_W'(b0 ^ $urandom_range(1, 1023));
        bus.req = '0;
        wait_rsp(WAITMAX, got, n);
        n = n + 1;
        n_checks++; if (!got || n !== LAT_OK || bus.rsp_valid !== (NREQ'(1) << w)) begin n_fail++; $display("FAIL opchg_valid: got n=%0d valid=%b expected n=%0d valid=%b", n, bus.rsp_valid, LAT_OK, NREQ'(1) << w); end
        n_checks++; if (bus.rsp_result !== prod(a0, b0)) begin n_fail++; $display("FAIL opchg_result: got %h expected %h", bus.rsp_result, prod(a0, b0)); end
        m_ptr = (w + 1) % NREQ;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit got; int unsigned n, w; logic [NREQ-1:0] mask, v; logic [PROD_W-1:0] r; logic e;
        int unsigned ra[NREQ], rb[NREQ];
        for (int unsigned it = 0; it < 12; it++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int unsigned i = 0; i < NREQ; i++) begin
                ra[i] = $urandom_range(0, 1023);
                rb[i] = $urandom_range(0, 1023);
                bus.op_a[IDX_W'(i)] = FRAC_W'(ra[i]);
                bus.op_b[IDX_W'(i)] = FRAC_W'(rb[i]);
            end
            w = pick(mask, m_ptr);
            issue(mask, got, n, v, r, e);
            n_checks++; if (!got || n !== LAT_OK) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d (seen=%b) expected %0d", it, n, got, LAT_OK); end
            n_checks++; if (v !== (NREQ'(1) << w)) begin n_fail++; $display("FAIL rand_grant[%0d]: mask=%b got %b expected %b", it, mask, v, NREQ'(1) << w); end
            n_checks++; if (r !== prod(ra[w], rb[w]) || e !== 1'b0) begin n_fail++; $display("FAIL rand_result[%0d]: got %h err=%b expected %h err=0", it, r, e, prod(ra[w], rb[w])); end
            m_ptr = (w + 1) % NREQ;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_all_four();
        test_timeout();
        test_reset_in_busy();
        test_operand_change();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
